// File: rtl/encoder_sample_ctrl.sv
// encoder_sample_ctrl: periodic encoder snapshot with saturated velocity, overspeed and overrun flags
module encoder_sample_ctrl #(
  parameter int REG_MAX = 64,
  parameter int PER_W   = 16,
  parameter int VEL_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [PER_W-1:0]          period,
  input  logic [VEL_W-1:0]          vel_limit,
  input  logic signed [REG_MAX-1:0] pulse_count,
  input  logic                      sample_ready,
  output logic                      sample_valid,
  output logic signed [REG_MAX-1:0] sample_pos,
  output logic signed [VEL_W-1:0]   sample_vel,
  output logic                      overspeed,
  output logic                      overrun,
  output logic                      running
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic signed [REG_MAX:0] VMAX = {{(REG_MAX+2-VEL_W){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [REG_MAX:0] VMIN = {{(REG_MAX+2-VEL_W){1'b1}}, {(VEL_W-1){1'b0}}};
  logic [1:0] state_q, state_d;
  logic signed [REG_MAX-1:0] prev_q, prev_d, pos_q, pos_d;
  logic [PER_W-1:0] tick_q, tick_d, reload;
  logic signed [VEL_W-1:0] vel_q, vel_d, vel_sat;
  logic valid_q, valid_d, ovs_q, ovs_d, ovr_q, ovr_d;
  logic signed [REG_MAX:0] delta;
  logic [VEL_W:0] vel_abs;
  logic tick, xfer;
  always_comb begin
    reload  = (period == '0) ? '0 : period - 1'b1;
    delta   = {pulse_count[REG_MAX-1], pulse_count} - {prev_q[REG_MAX-1], prev_q};
    vel_sat = (delta > VMAX) ? VMAX[VEL_W-1:0] : (delta < VMIN) ? VMIN[VEL_W-1:0] : delta[VEL_W-1:0];
    vel_abs = vel_sat[VEL_W-1] ? -{vel_sat[VEL_W-1], vel_sat} : {1'b0, vel_sat};
    tick    = (state_q == RUN) && (tick_q == '0);
    xfer    = valid_q && sample_ready;
    state_d = state_q;
    prev_d  = prev_q;
    tick_d  = tick_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    ovs_d   = ovs_q;
    ovr_d   = ovr_q;
    valid_d = valid_q && !xfer;
    if (!enable) begin
      state_d = IDLE;
      tick_d  = '0;
      valid_d = 1'b0;
      ovs_d   = 1'b0;
      ovr_d   = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = PRIME;
    end else if (state_q == PRIME) begin
      prev_d  = pulse_count;
      tick_d  = reload;
      state_d = RUN;
    end else if (state_q != RUN) begin
      state_d = IDLE;
    end else if (tick) begin
      pos_d   = pulse_count;
      vel_d   = vel_sat;
      ovs_d   = vel_abs > {1'b0, vel_limit};
      prev_d  = pulse_count;
      tick_d  = reload;
      valid_d = 1'b1;
      ovr_d   = ovr_q || (valid_q && !sample_ready);
    end else begin
      tick_d  = tick_q - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      tick_q  <= '0;
      pos_q   <= '0;
      vel_q   <= '0;
      valid_q <= 1'b0;
      ovs_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      pos_q   <= pos_d;
      vel_q   <= vel_d;
      valid_q <= valid_d;
      ovs_q   <= ovs_d;
      ovr_q   <= ovr_d;
    end
  end
  assign sample_valid = valid_q;
  assign sample_pos   = pos_q;
  assign sample_vel   = vel_q;
  assign overspeed    = ovs_q;
  assign overrun      = ovr_q;
  assign running      = (state_q == PRIME) || (state_q == RUN);
endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// tb_encoder_sample_ctrl: randomized and directed checks against an event-scheduled reference model
module tb_encoder_sample_ctrl;
  localparam int REG_MAX = 16;
  localparam int PER_W   = 8;
  localparam int VEL_W   = 8;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sample_ready = 1'b0;
  logic [PER_W-1:0] period = '0;
  logic [VEL_W-1:0] vel_limit = '0;
  logic signed [REG_MAX-1:0] pc = '0;
  logic sample_valid, overspeed, overrun, running;
  logic signed [REG_MAX-1:0] sample_pos;
  logic signed [VEL_W-1:0] sample_vel;
  int n_chk = 0, n_pass = 0;
  int ms;
  longint cyc, next_tick, mprev, mpos, mvel;
  bit mvalid, movs, movr;
  encoder_sample_ctrl #(.REG_MAX(REG_MAX), .PER_W(PER_W), .VEL_W(VEL_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .vel_limit(vel_limit),
    .pulse_count(pc), .sample_ready(sample_ready), .sample_valid(sample_valid),
    .sample_pos(sample_pos), .sample_vel(sample_vel), .overspeed(overspeed),
    .overrun(overrun), .running(running)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    ms = 0; cyc = 0; next_tick = 0; mprev = 0; mpos = 0; mvel = 0;
    mvalid = 0; movs = 0; movr = 0;
  endtask
  task automatic model();
    longint p, x, d, lim;
    cyc++;
    p = (period == 0) ? 1 : longint'(period);
    x = longint'(pc);
    lim = longint'(1) <<< (VEL_W - 1);
    if (!enable) begin
      ms = 0; mvalid = 0; movs = 0; movr = 0;
    end else if (ms == 0) ms = 1;
    else if (ms == 1) begin
      mprev = x; next_tick = cyc + p; ms = 2;
    end else if (cyc == next_tick) begin
      d = x - mprev;
      if (d > lim - 1) d = lim - 1;
      if (d < -lim) d = -lim;
      if (mvalid && !sample_ready) movr = 1;
      mpos = x; mvel = d; mprev = x; mvalid = 1;
      movs = ((d < 0) ? -d : d) > longint'(vel_limit);
      next_tick = cyc + p;
    end else if (mvalid && sample_ready) mvalid = 0;
  endtask
  task automatic check_all();
    chk("valid", sample_valid, mvalid);
    chk("pos", longint'(sample_pos), mpos);
    chk("vel", longint'(sample_vel), mvel);
    if (mvalid) chk("overspeed", overspeed, movs);
    chk("overrun", overrun, movr);
    chk("running", running, ms != 0);
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask
  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (sample_valid) return;
    end
    chk("wait_valid_timeout", 0, 1);
  endtask
  task automatic restart();
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask
  initial begin
    longint saved;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step();
    // stationary encoder
    period = 4; pc = 100; sample_ready = 1; vel_limit = 0;
    restart();
    repeat (20) step();
    chk("stat_pos", longint'(sample_pos), 100);
    chk("stat_vel", longint'(sample_vel), 0);
    // forward then reverse ramp
    period = 10; vel_limit = 9;
    restart();
    repeat (25) begin step(); pc = pc + 1; end
    chk("fwd_vel", longint'(sample_vel), 10);
    repeat (20) begin step(); pc = pc - 1; end
    chk("rev_vel", longint'(sample_vel), -10);
    // overrun is sticky until idle
    period = 3; sample_ready = 0;
    restart();
    repeat (9) step();
    chk("ovr_set", overrun, 1);
    sample_ready = 1;
    repeat (6) step();
    chk("ovr_sticky", overrun, 1);
    enable = 0;
    step();
    chk("ovr_clear", overrun, 0);
    // period 1 with continuous ready
    period = 1; sample_ready = 1;
    restart();
    repeat (17) step();
    chk("p1_valid", sample_valid, 1);
    chk("p1_ovr", overrun, 0);
    // saturation both ways
    pc = 0; period = 2; vel_limit = 200;
    restart();
    step(); step();
    pc = 1000;
    wait_valid(10);
    chk("sat_hi", longint'(sample_vel), 127);
    pc = 0;
    restart();
    step(); step();
    pc = -1000;
    wait_valid(10);
    chk("sat_lo", longint'(sample_vel), -128);
    // enable drops on a tick cycle
    period = 3; sample_ready = 0;
    restart();
    wait_valid(10);
    saved = longint'(sample_pos);
    for (int i = 0; i < 10 && cyc + 1 != next_tick; i++) step();
    pc = pc + 5; enable = 0;
    step();
    chk("drop_valid", sample_valid, 0);
    chk("drop_running", running, 0);
    chk("drop_pos", longint'(sample_pos), saved);
    // random traffic
    enable = 1;
    repeat (600) begin
      int r;
      step();
      enable = ($urandom_range(0, 40) != 0);
      period = PER_W'($urandom_range(0, 5));
      sample_ready = $urandom_range(0, 2) != 0;
      vel_limit = VEL_W'($urandom_range(0, 255));
      r = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4000) - 2000 : $urandom_range(0, 60) - 30;
      pc = pc + REG_MAX'(r);
    end
    // asynchronous reset while a sample is pending
    period = 3; sample_ready = 0;
    restart();
    wait_valid(10);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", sample_valid, 0);
    chk("rst_running", running, 0);
    check_all();
    @(negedge clk);
    rst = 1'b0; enable = 0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/encoder_sample_ctrl.md
# encoder_sample_ctrl

Periodic sampling scheduler for the quadrature encoder interface. It snapshots the free-running `pulse_count` from `encoder_in` at a programmable interval and derives a per-interval velocity (count delta) with saturation and an overspeed flag. Each sample goes to the downstream control loop over a valid/ready handshake, and overruns are detected. It sits between `encoder_in` and the position/velocity controller.

## Interface
- `REG_MAX`, 64: width of `pulse_count` and `sample_pos`, signed.
- `PER_W`, 16: width of the `period` configuration.
- `VEL_W`, 32: width of `sample_vel` (signed) and `vel_limit` (unsigned).

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request; low forces IDLE.
- `period`  in  PER_W  sample interval in clocks; 0 is treated as 1.
- `vel_limit`  in  VEL_W  overspeed threshold on |velocity|, unsigned.
- `pulse_count`  in  REG_MAX  signed count from `encoder_in`.
- `sample_ready`  in  1  consumer accepts a sample.
- `sample_valid`  out  1  a sample is pending.
- `sample_pos`  out  REG_MAX  `pulse_count` at the sample instant, signed.
- `sample_vel`  out  VEL_W  saturated delta since the previous sample, signed.
- `overspeed`  out  1  |`sample_vel`| > `vel_limit`; qualified by `sample_valid`.
- `overrun`  out  1  sticky: an unaccepted sample was overwritten.
- `running`  out  1  high in PRIME or RUN.

## Operation
- Reset value of every output is 0. Internal state on reset:
  - FSM = IDLE
  - `prev_pos` = 0
  - `tick_cnt` = 0
- FSM states:
  - IDLE: counter held at 0; no samples generated.
    - `enable`=1 → PRIME.
  - PRIME (one cycle):
    - `prev_pos` ← `pulse_count`.
    - `tick_cnt` ← max(`period`,1) − 1.
    - → RUN.
  - RUN: `tick_cnt` decrements each cycle. When `tick_cnt`==0 (a tick):
    - `sample_pos` ← `pulse_count`.
    - `sample_vel` ← sat(`pulse_count` − `prev_pos`).
    - `overspeed` ← (|delta_sat| > `vel_limit`).
    - `prev_pos` ← `pulse_count`.
    - `tick_cnt` ← max(`period`,1) − 1, using the live `period` value at reload.
    - `sample_valid` ← 1.
  - In any state, `enable`=0 → IDLE on the next edge. On entry to IDLE:
    - `sample_valid`, `overrun` and `overspeed` are cleared.
    - `sample_pos` and `sample_vel` hold their values.
- Arithmetic:
  - Delta is computed at REG_MAX+1 bits (no wrap).
  - It is then clamped to [−2^(VEL_W−1), 2^(VEL_W−1)−1].
  - The absolute value for `overspeed` is taken on the clamped value, at VEL_W+1 bits.
- Handshake:
  - A transfer occurs on a cycle with `sample_valid`&&`sample_ready`; `sample_valid` drops on the next edge.
  - While `sample_valid`=1, the outputs are stable until transfer or the next tick.
  - `sample_ready` may be high with `sample_valid` low; this has no effect.
- Simultaneous events:
  - Tick and transfer in the same cycle: the new sample loads, `sample_valid` stays 1, no overrun.
  - Tick while `sample_valid`=1 and no transfer: the sample is overwritten and `overrun` ← 1. `overrun` stays set until IDLE or reset.
  - `enable` falling on a tick cycle: IDLE wins; no sample is loaded.
- Reset asserted mid-operation: everything returns to reset values immediately, independent of `clk`.

## Timing
- `enable` high at edge E0 → PRIME after E0, `running`=1.
- `prev_pos` is captured at E0+1.
- Ticks occur at edges E0+1+N·P (P = max(`period`,1), N ≥ 1). `sample_valid` and the data are visible right after each tick edge.
- Sampling latency is 0 cycles: `sample_pos` equals `pulse_count` as presented at the tick edge.
- P=1: a sample is taken every cycle. The consumer must hold `sample_ready`=1 to avoid overrun.
- A `period` change takes effect at the next reload. The interval in progress is not shortened.

## Test plan
- **Reset:** assert `rst` mid-RUN with `sample_valid`=1 → all outputs 0 asynchronously, FSM in IDLE; after release with `enable`=0, outputs remain 0.
- **Stationary:** `period`=4, `pulse_count` held at 100, `sample_ready`=1 → samples every 4 clocks with `sample_pos`=100, `sample_vel`=0, `overspeed`=0.
- **Forward/reverse ramps:** `period`=10.
  - `pulse_count` +1/clk → `sample_vel`=10.
  - Then −1/clk → `sample_vel`=−10.
  - `vel_limit`=9 → `overspeed`=1 on both.
- **Overrun:** `period`=3, `sample_ready`=0 for 2 ticks → second tick overwrites, `overrun`=1 and sticky; later transfers do not clear it; `enable` low clears it.
- **Simultaneous tick+ready:** `period`=1, `sample_ready`=1 continuously → `sample_valid` stays 1 every cycle, `overrun` stays 0.
- **Saturation:** VEL_W=8, `prev_pos`=0, then `pulse_count` jumps to +1000 → `sample_vel`=127; jump −1000 from 0 → `sample_vel`=−128.
- **Enable drop:** deassert `enable` on a tick cycle → no new sample, `sample_valid`=0 next cycle, `running`=0.
